conv1d_layer_seq: RTL and testbench

- Parametrised, time-multiplexed successor to the fully parallel 4-in/8-out, 5-tap quantised conv layer.
- One signed MAC evaluates every output channel over every input channel and tap, then applies bias, an arithmetic right shift and symmetric 8-bit saturation.
- Weights and biases are run-time loadable instead of hard-coded.
- Sits between the layer-1 window buffer and the pooling stage; uses valid/ready handshakes on both sides.

---
 rtl/conv1d_pkg.sv | 30 +++
 rtl/conv1d_layer_seq_if.sv | 27 ++
 rtl/conv1d_wmem.sv | 24 ++
 rtl/conv1d_layer_seq.sv | 161 ++++++++++++++++
 tb/tb_conv1d_layer_seq.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/conv1d_pkg.sv
// Shared types, saturation limits and the requantise helper for the sequential conv1d layer.
// Latency: none (types and functions only); no backpressure.
package conv1d_pkg;

  localparam int PKG_DW    = 8;
  localparam int PKG_ACC_W = 24;

  typedef logic signed [PKG_DW-1:0]    data_t;
  typedef logic signed [PKG_ACC_W-1:0] acc_t;

  localparam acc_t SAT_MAX = acc_t'(127);
  localparam acc_t SAT_MIN = -acc_t'(127);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_REQ,
    ST_DONE
  } state_t;

  // Floor shift, then clamp symmetrically so -128 is never produced.
  function automatic data_t sat_shift(input acc_t a, input int unsigned shift);
    acc_t r;
    r = a >>> shift;
    if (r > SAT_MAX) return data_t'(SAT_MAX);
    if (r < SAT_MIN) return data_t'(SAT_MIN);
    return r[PKG_DW-1:0];
  endfunction

endpackage

// File: rtl/conv1d_layer_seq_if.sv
// Window-in / result-out valid-ready bundle; master is the upstream/downstream side, slave is the layer.
// Latency: none (wires only); backpressure carried by in_ready and out_ready.
interface conv1d_layer_seq_if #(
  parameter int IN_CH  = 4,
  parameter int KSIZE  = 5,
  parameter int OUT_CH = 8,
  parameter int DW     = 8
);

  logic                        in_valid;
  logic                        in_ready;
  logic [IN_CH*KSIZE*DW-1:0]   in_data;
  logic                        out_valid;
  logic                        out_ready;
  logic [OUT_CH*DW-1:0]        out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/conv1d_wmem.sv
// Single-port weight RAM: one shared address for write (while idle) and combinational read.
// Latency: read 0 cycles, write lands on the next edge; no backpressure, caller owns the port.
module conv1d_wmem
  import conv1d_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = PKG_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/conv1d_layer_seq.sv
// Time-multiplexed conv1d: one MAC per cycle, then bias, floor shift, symmetric sat (ReLU clamp if CONV1D_RELU_EN).
// Result OUT_CH*(IN_CH*KSIZE+1) enabled cycles after accept; in_ready low until out_ready takes it; en low freezes all.
module conv1d_layer_seq
  import conv1d_pkg::*;
#(
  parameter int IN_CH  = 4,
  parameter int OUT_CH = 8,
  parameter int KSIZE  = 5,
  parameter int DW     = PKG_DW,
  parameter int ACC_W  = PKG_ACC_W,
  parameter int SHIFT  = 9,
  localparam int WAW   = $clog2(OUT_CH*IN_CH*KSIZE),
  localparam int BAW   = (OUT_CH > 1) ? $clog2(OUT_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  conv1d_layer_seq_if.slave       bus,
  input  logic                    w_we,
  input  logic [WAW-1:0]          w_addr,
  input  logic signed [DW-1:0]    w_data,
  input  logic                    b_we,
  input  logic [BAW-1:0]          b_addr,
  input  logic signed [ACC_W-1:0] b_data,
  output logic                    busy
);

  localparam int IW = (IN_CH > 1) ? $clog2(IN_CH) : 1;
  localparam int KW = (KSIZE > 1) ? $clog2(KSIZE) : 1;

  state_t                    state_q;
  logic [IN_CH*KSIZE*DW-1:0] x_q;
  logic [BAW-1:0]            o_q;
  logic [IW-1:0]             i_q;
  logic [KW-1:0]             k_q;
  logic [WAW-1:0]            wa_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [OUT_CH*DW-1:0]      out_q;
  logic                      in_rdy_q;
  logic                      out_vld_q;
  logic                      busy_q;
  logic signed [ACC_W-1:0]   bias_q [2**BAW];

  logic                      is_idle;
  logic [WAW-1:0]            mem_addr;
  logic [DW-1:0]             w_rd;
  logic signed [DW-1:0]      x_tap;
  logic signed [2*DW-1:0]    prod;
  logic signed [ACC_W-1:0]   acc_d;
  data_t                     res_d;
  logic                      last_k;
  logic                      last_i;
  logic                      last_o;

  assign is_idle = (state_q == ST_IDLE);

  // Weight order (o,i,k) matches the MAC walk, so a linear counter is the read address.
  assign mem_addr = is_idle ? w_addr : wa_q;

  conv1d_wmem #(
    .AW (WAW),
    .DW (DW)
  ) u_wmem (
    .clk   (clk),
    .we    (en && w_we && is_idle),
    .addr  (mem_addr),
    .wdata (w_data),
    .rdata (w_rd)
  );

  always_ff @(posedge clk) begin
    if (en && b_we && is_idle) bias_q[b_addr] <= b_data;
  end

  assign x_tap  = x_q[(int'(i_q)*KSIZE + int'(k_q))*DW +: DW];
  assign prod   = x_tap * $signed(w_rd);
  assign acc_d  = acc_q + {{(ACC_W-2*DW){prod[2*DW-1]}}, prod};
  assign last_k = (k_q == KW'(KSIZE-1));
  assign last_i = (i_q == IW'(IN_CH-1));
  assign last_o = (o_q == BAW'(OUT_CH-1));

  always_comb begin
    res_d = sat_shift(acc_q + bias_q[o_q], SHIFT);
`ifdef CONV1D_RELU_EN
    if (res_d < 0) res_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      o_q       <= '0;
      i_q       <= '0;
      k_q       <= '0;
      wa_q      <= '0;
      acc_q     <= '0;
      out_q     <= '0;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            x_q      <= bus.in_data;
            acc_q    <= '0;
            o_q      <= '0;
            i_q      <= '0;
            k_q      <= '0;
            wa_q     <= '0;
            in_rdy_q <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc_q <= acc_d;
          wa_q  <= wa_q + 1'b1;
          if (last_k) begin
            k_q <= '0;
            if (last_i) begin
              i_q     <= '0;
              state_q <= ST_REQ;
            end else begin
              i_q <= i_q + 1'b1;
            end
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        ST_REQ: begin
          out_q[int'(o_q)*DW +: DW] <= res_d;
          acc_q <= '0;
          if (last_o) begin
            out_vld_q <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            o_q     <= o_q + 1'b1;
            state_q <= ST_MAC;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_rdy_q;
  assign bus.out_valid = out_vld_q;
  assign bus.out_data  = out_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_conv1d_layer_seq.sv
// Directed bench for conv1d_layer_seq: table of weight/input/bias patterns plus hold, en-stall and reset sequences.
module tb_conv1d_layer_seq;

  localparam int LAT = 168;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              w_we;
  logic [7:0]        w_addr;
  logic signed [7:0] w_data;
  logic              b_we;
  logic [2:0]        b_addr;
  logic signed [23:0] b_data;
  logic              busy;

  int checks = 0;
  int fails  = 0;

  conv1d_layer_seq_if #(.IN_CH(4), .KSIZE(5), .OUT_CH(8), .DW(8)) bus ();

  conv1d_layer_seq dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .bus    (bus),
    .w_we   (w_we),
    .w_addr (w_addr),
    .w_data (w_data),
    .b_we   (b_we),
    .b_addr (b_addr),
    .b_data (b_data),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int w_fill; int w000; int x_fill; int x00;
    int b0; int b1; int b_rest;
    int e0; int e1; int e_rest;
  } vec_t;

  vec_t vecs [6];

  function automatic int relu(input int v);
`ifdef CONV1D_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  function automatic int exp_ch(input vec_t v, input int o);
    return relu((o == 0) ? v.e0 : (o == 1) ? v.e1 : v.e_rest);
  endfunction

  function automatic logic [159:0] mkx(input vec_t v);
    logic [159:0] x;
    for (int e = 0; e < 20; e++) x[e*8 +: 8] = 8'((e == 0) ? v.x00 : v.x_fill);
    return x;
  endfunction

  function automatic int ch_of(input int o);
    logic signed [7:0] c;
    c = bus.out_data[o*8 +: 8];
    return int'(c);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input vec_t v);
    for (int a = 0; a < 160; a++) begin
      w_we = 1'b1; w_addr = 8'(a); w_data = 8'((a == 0) ? v.w000 : v.w_fill);
      tick();
    end
    w_we = 1'b0;
    for (int b = 0; b < 8; b++) begin
      b_we = 1'b1; b_addr = 3'(b);
      b_data = 24'((b == 0) ? v.b0 : (b == 1) ? v.b1 : v.b_rest);
      tick();
    end
    b_we = 1'b0;
  endtask

  // Accept one window, then count edges until out_valid; optional en-low gap.
  task automatic start_and_wait(input vec_t v, input int stall_at, input int stall_len,
                                output int lat);
    bus.in_data  = mkx(v);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 2000) begin
      if (stall_len > 0 && lat == stall_at) en = 1'b0;
      if (stall_len > 0 && lat == stall_at + stall_len) en = 1'b1;
      tick();
      lat++;
    end
    en = 1'b1;
  endtask

  task automatic check_outputs(input vec_t v, input string tag);
    for (int o = 0; o < 8; o++)
      chk($sformatf("%s_ch%0d", tag, o), ch_of(o), exp_ch(v, o));
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, "_vld_drop"}, int'(bus.out_valid), 0);
    chk({tag, "_rdy_back"}, int'(bus.in_ready), 1);
  endtask

  initial begin
    int lat;
    int bad_vld, bad_rdy, bad_dat, seen_vld;

    vecs[0] = '{127, 127, 127, 127, 0, 0, 0, 127, 127, 127};
    vecs[1] = '{-127, -127, 127, 127, 0, 0, 0, -127, -127, -127};
    vecs[2] = '{0, 64, 0, 64, 0, 0, 0, 8, 0, 0};
    vecs[3] = '{0, 0, 0, 0, -77, 600, 0, -1, 1, 0};
    vecs[4] = '{3, 3, -5, -5, -1000, 100000, 1000, -3, 127, 1};
    vecs[5] = '{-2, -2, 100, 100, 4000, -70000, 0, 0, -127, -8};

    rst = 1'b0; en = 1'b1;
    w_we = 1'b0; w_addr = '0; w_data = '0;
    b_we = 1'b0; b_addr = '0; b_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", int'(bus.in_ready), 1);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_data_nz", int'(|bus.out_data), 0);
    rst = 1'b1;
    tick();

    for (int v = 0; v < 6; v++) begin
      load_vec(vecs[v]);
      chk($sformatf("v%0d_in_ready", v), int'(bus.in_ready), 1);
      start_and_wait(vecs[v], 0, 0, lat);
      chk($sformatf("v%0d_latency", v), lat, LAT);
      check_outputs(vecs[v], $sformatf("v%0d", v));
      release_result($sformatf("v%0d", v));
    end

    // Hold result for 50 cycles with a weight write that must be ignored.
    start_and_wait(vecs[5], 0, 0, lat);
    chk("hold_latency", lat, LAT);
    bad_vld = 0; bad_rdy = 0; bad_dat = 0;
    for (int c = 0; c < 50; c++) begin
      w_we = (c == 10); w_addr = '0; w_data = 8'sd127;
      tick();
      if (bus.out_valid !== 1'b1) bad_vld++;
      if (bus.in_ready !== 1'b0) bad_rdy++;
      for (int o = 0; o < 8; o++) if (ch_of(o) != exp_ch(vecs[5], o)) bad_dat++;
    end
    w_we = 1'b0;
    chk("hold_out_valid_drops", bad_vld, 0);
    chk("hold_in_ready_highs", bad_rdy, 0);
    chk("hold_out_data_changes", bad_dat, 0);
    chk("hold_busy", int'(busy), 1);
    release_result("hold");
    start_and_wait(vecs[5], 0, 0, lat);
    chk("after_hold_latency", lat, LAT);
    check_outputs(vecs[5], "after_hold");
    release_result("after_hold");

    // Reset in the middle of MAC: partial work discarded, no result appears.
    bus.in_data = mkx(vecs[0]); bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 50; c++) tick();
    chk("mid_busy", int'(busy), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    chk("mid_rst_out_valid", int'(bus.out_valid), 0);
    chk("mid_rst_out_data_nz", int'(|bus.out_data), 0);
    tick();
    rst = 1'b1;
    seen_vld = 0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (bus.out_valid) seen_vld++;
    end
    chk("post_rst_spurious_valid", seen_vld, 0);

    // en low for 20 cycles mid-MAC delays the result by exactly 20.
    start_and_wait(vecs[5], 30, 20, lat);
    chk("stall_latency", lat, LAT + 20);
    check_outputs(vecs[5], "stall");
    release_result("stall");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
